ram_burst_controller: RTL and testbench
=======================================

Name: ram_burst_controller

Overview:
- Sits directly downstream of the cache, between the cache's RAM-side port and the external word-wide SRAM.
- Converts one cache block request into a burst of single-word SRAM accesses:
  - refill: SRAM read toward the cache;
  - writeback: cache toward SRAM write.
- Inserts a fixed number of wait states per access.
- Signals completion to the cache with a one-cycle pulse.

Parameters:
- BLOCKSIZEBITS, 5, log2 of block size in bytes; words per block W = 2^(BLOCKSIZEBITS-2), 8 by default.
- WAITSTATES, 2, extra cycles per SRAM access; each access occupies WAITSTATES+1 cycles; legal range 0..15.

Ports:
- Takt  in  1  clock; all state changes on its rising edge.
- nReset  in  1  reset, synchronous, active-low.
- Anfrage  in  1  cache request; sampled only in IDLE.
- AnfrageSchreiben  in  1  1 = writeback, 0 = refill; sampled with Anfrage.
- AnfrageAdresse  in  32  byte address inside the target block.
- CacheSchreibDaten  in  32  writeback word for the current WortIndex; combinational from the cache.
- WortIndex  out  BLOCKSIZEBITS-2  word index currently being transferred.
- CacheLesDaten  out  32  refill word.
- CacheLesGueltig  out  1  one-cycle pulse; CacheLesDaten is valid for WortIndex.
- Fertig  out  1  one-cycle pulse; burst complete.
- Beschaeftigt  out  1  high whenever state is not IDLE.
- RAMAdresse  out  32  SRAM word byte-address.
- RAMLesen  out  1  SRAM read strobe.
- RAMSchreiben  out  1  SRAM write strobe.
- RAMSchreibDaten  out  32  SRAM write data.
- RAMLesDaten  in  32  SRAM read data; valid in the last cycle of an access.

Behaviour:
- Reset (nReset low at a rising edge):
  - state goes to IDLE;
  - all outputs are 0, including WortIndex and RAMAdresse;
  - the wait counter and word counter are cleared.
  - Reset mid-burst aborts immediately; no further strobes are issued and Fertig is not asserted.
- Block base = AnfrageAdresse with the low BLOCKSIZEBITS bits cleared. It is latched on acceptance together with AnfrageSchreiben.
- Word address = base + (WortIndex << 2). Word-index arithmetic is modulo W.
- IDLE:
  - Anfrage=1 accepts the request. Next state is ZUGRIFF, with word counter = start index and wait counter = 0.
  - Otherwise stay in IDLE.
  - Anfrage while not in IDLE is ignored. The cache holds Anfrage until it sees Fertig.
- ZUGRIFF:
  - RAMAdresse = current word address.
  - RAMLesen = !write; RAMSchreiben = write.
  - RAMSchreibDaten = CacheSchreibDaten, registered at the entry to each access and held stable for the whole access.
  - The wait counter increments each cycle.
  - When the counter equals WAITSTATES, the access ends at that edge:
    - refill: CacheLesDaten <= RAMLesDaten and CacheLesGueltig pulses in the next cycle with the matching WortIndex;
    - if this was the last word, go to FERTIG; otherwise advance the word counter, reset the wait counter and stay in ZUGRIFF.
- Strobes stay continuously high across back-to-back words. RAMAdresse changes only at word boundaries.
- FERTIG:
  - one cycle: Fertig=1, Beschaeftigt=1, strobes low.
  - Then go to IDLE. A new request can be accepted in the cycle after FERTIG.
- Latency: a burst lasts W*(WAITSTATES+1) ZUGRIFF cycles plus 1 FERTIG cycle. With defaults this is 24+1 cycles.
- WAITSTATES=0: one word per cycle, and strobes stay high for W cycles.
- Word-counter wrap: the index wraps from W-1 to 0. The last word is start index + W-1 (mod W).

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined: refill starts at word AnfrageAdresse[BLOCKSIZEBITS-1:2] and wraps modulo W. The requested word arrives first.
- Not defined, or writeback in either case: the start index is always 0 and words go in ascending order.

Decomposition:
- Shared package cache_pkg holds:
  - state enum {IDLE, ZUGRIFF, FERTIG};
  - function words_per_block(BLOCKSIZEBITS);
  - the word-offset width constant, also used by the cache.
- One sub-module is natural: ram_wait_counter.
  - Loadable counter with terminal-count flag for WAITSTATES.
  - Reusable by the later I/O controller.

Test Plan:
- Refill with defaults: Anfrage=1, AnfrageSchreiben=0, AnfrageAdresse=0x0000_1234.
  - Eight reads at RAMAdresse 0x1220, 0x1224, ..., 0x123C, each RAMLesen for 3 cycles.
  - CacheLesGueltig ×8 with WortIndex 0..7.
  - Fertig exactly 25 cycles after acceptance.
- Writeback: AnfrageSchreiben=1, base 0x0000_4000, cache returns 0xA0+WortIndex.
  - RAMSchreiben high for 24 cycles.
  - RAMSchreibDaten 0xA0..0xA7 at 0x4000..0x401C; no RAMLesen.
- Critical word first (macro defined), AnfrageAdresse=0x0000_1238.
  - Read order WortIndex 6,7,0,1,...,5, first address 0x1238, wrap 0x123C→0x1220.
  - Without the macro: order 0..7.
- WAITSTATES=0 refill: CacheLesGueltig on 8 consecutive cycles; Fertig on cycle 9; Beschaeftigt high for 9 cycles.
- Reset mid-burst: nReset=0 during word 3.
  - At the next edge all outputs are 0 and state is IDLE; no Fertig.
  - A new request accepted afterwards completes normally.
- Anfrage held high through Fertig: the next burst starts in the cycle after FERTIG; no request is lost or duplicated.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared cache/RAM-side definitions.
// Holds the burst controller state encoding, the byte-offset-in-word width
// and a helper that derives the number of 32-bit words in a cache block.
package cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ZUGRIFF,
      FERTIG
   } state_e;

   // Byte offset bits inside one 32-bit word; the word index starts above it.
   localparam int WORD_OFS_BITS = 2;

   function automatic int words_per_block(input int blocksizebits);
      return 1 << (blocksizebits - WORD_OFS_BITS);
   endfunction

endpackage

// File: rtl/ram_wait_counter.sv
// Wait-state counter for single-word SRAM accesses.
// Counts the cycles of one access and flags the last one (terminal count).
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  synchronous active-low reset
//   clr_i   load zero (no access in progress)
//   en_i    count this cycle; wraps to zero on terminal count
//   tc_o    counter equals WAITSTATES, i.e. this is the last access cycle
module ram_wait_counter #(
   parameter int WAITSTATES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [3:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == 4'(WAITSTATES));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || (en_i && tc_o)) cnt_d = '0;
      else if (en_i)               cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ram_burst_controller.sv
// Cache block <-> word-wide SRAM burst controller.
// Turns one cache block request into W single-word SRAM accesses of
// WAITSTATES+1 cycles each (refill = read, writeback = write), then pulses
// Fertig for one cycle.
// Ports:
//   Takt, nReset                clock / synchronous active-low reset
//   Anfrage, AnfrageSchreiben,  block request, direction (1 = writeback),
//   AnfrageAdresse              byte address inside the block
//   CacheSchreibDaten           writeback word for WortIndex (from cache)
//   WortIndex                   word index presented to the cache
//   CacheLesDaten/-Gueltig      refill word and its one-cycle valid pulse
//   Fertig, Beschaeftigt        burst done pulse / not idle
//   RAMAdresse, RAMLesen, RAMSchreiben, RAMSchreibDaten, RAMLesDaten  SRAM side
// Build option: define CRITICAL_WORD_FIRST_EN to start refills at the
// requested word (wrapping modulo W); otherwise every burst starts at word 0.
module ram_burst_controller
   import cache_pkg::*;
#(
   parameter int BLOCKSIZEBITS = 5,
   parameter int WAITSTATES    = 2
) (
   input  logic                     Takt,
   input  logic                     nReset,
   input  logic                     Anfrage,
   input  logic                     AnfrageSchreiben,
   input  logic [31:0]              AnfrageAdresse,
   input  logic [31:0]              CacheSchreibDaten,
   output logic [BLOCKSIZEBITS-3:0] WortIndex,
   output logic [31:0]              CacheLesDaten,
   output logic                     CacheLesGueltig,
   output logic                     Fertig,
   output logic                     Beschaeftigt,
   output logic [31:0]              RAMAdresse,
   output logic                     RAMLesen,
   output logic                     RAMSchreiben,
   output logic [31:0]              RAMSchreibDaten,
   input  logic [31:0]              RAMLesDaten
);

   localparam int          IW       = BLOCKSIZEBITS - WORD_OFS_BITS;
   localparam logic [31:0] OFS_MASK = 32'((64'd1 << BLOCKSIZEBITS) - 64'd1);

   state_e          state_q, state_d;
   logic [IW-1:0]   wort_q, wort_d;     // word being accessed on the SRAM
   logic [IW-1:0]   last_q, last_d;     // final word of this burst
   logic [IW-1:0]   gidx_q, gidx_d;     // word belonging to the refill pulse
   logic            schreib_q, schreib_d;
   logic            gueltig_q, gueltig_d;
   logic [31:0]     base_q, base_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic [IW-1:0]   start_idx;
   logic            tc, zugriff, last_word;

   assign zugriff   = (state_q == ZUGRIFF);
   assign last_word = (wort_q == last_q);

   ram_wait_counter #(.WAITSTATES(WAITSTATES)) u_wait (
      .clk_i  (Takt),
      .rst_ni (nReset),
      .clr_i  (!zugriff),
      .en_i   (zugriff),
      .tc_o   (tc)
   );

`ifdef CRITICAL_WORD_FIRST_EN
   assign start_idx = AnfrageSchreiben ? '0 : AnfrageAdresse[BLOCKSIZEBITS-1:WORD_OFS_BITS];
`else
   assign start_idx = '0;
`endif

   always_comb begin
      state_d   = state_q;
      wort_d    = wort_q;
      last_d    = last_q;
      gidx_d    = gidx_q;
      schreib_d = schreib_q;
      gueltig_d = 1'b0;
      base_d    = base_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (Anfrage) begin
               state_d   = ZUGRIFF;
               wort_d    = start_idx;
               last_d    = start_idx - IW'(1);
               schreib_d = AnfrageSchreiben;
               base_d    = AnfrageAdresse & ~OFS_MASK;
               // Writebacks start at word 0, which WortIndex shows in IDLE.
               wdata_d   = CacheSchreibDaten;
            end
         end
         ZUGRIFF: begin
            if (tc) begin
               if (!schreib_q) begin
                  rdata_d   = RAMLesDaten;
                  gueltig_d = 1'b1;
                  gidx_d    = wort_q;
               end
               if (last_word) state_d = FERTIG;
               else begin
                  wort_d  = wort_q + IW'(1);
                  // WortIndex already shows the next word in this cycle.
                  wdata_d = CacheSchreibDaten;
               end
            end
         end
         FERTIG:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Takt) begin
      if (!nReset) begin
         state_q   <= IDLE;
         wort_q    <= '0;
         last_q    <= '0;
         gidx_q    <= '0;
         schreib_q <= 1'b0;
         gueltig_q <= 1'b0;
         base_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         wort_q    <= wort_d;
         last_q    <= last_d;
         gidx_q    <= gidx_d;
         schreib_q <= schreib_d;
         gueltig_q <= gueltig_d;
         base_q    <= base_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   // The refill pulse names the word just read. A writeback looks one word
   // ahead in the last access cycle so the cache data can be registered at
   // the next access entry and then stays stable for that whole access.
   always_comb begin
      WortIndex = '0;
      if (gueltig_q)                                 WortIndex = gidx_q;
      else if (zugriff && schreib_q && tc && !last_word) WortIndex = wort_q + IW'(1);
      else if (zugriff)                              WortIndex = wort_q;
   end

   assign CacheLesDaten   = rdata_q;
   assign CacheLesGueltig = gueltig_q;
   assign Fertig          = (state_q == FERTIG);
   assign Beschaeftigt    = (state_q != IDLE);
   assign RAMAdresse      = zugriff ? (base_q + (32'(wort_q) << WORD_OFS_BITS)) : '0;
   assign RAMLesen        = zugriff && !schreib_q;
   assign RAMSchreiben    = zugriff && schreib_q;
   assign RAMSchreibDaten = (zugriff && schreib_q) ? wdata_q : '0;

endmodule

// File: tb/tb_ram_burst_controller.sv
// Bench for ram_burst_controller: default instance plus a WAITSTATES=0 one.
module tb_ram_burst_controller;

   logic Takt = 1'b0;
   always #5 Takt = ~Takt;

   logic        nReset;
   logic        Anfrage, AnfrageSchreiben;
   logic [31:0] AnfrageAdresse, CacheSchreibDaten, CacheLesDaten;
   logic [31:0] RAMAdresse, RAMSchreibDaten, RAMLesDaten;
   logic [2:0]  WortIndex;
   logic        CacheLesGueltig, Fertig, Beschaeftigt, RAMLesen, RAMSchreiben;

   logic        z_Anfrage, z_AnfrageSchreiben;
   logic [31:0] z_AnfrageAdresse, z_CacheSchreibDaten, z_CacheLesDaten;
   logic [31:0] z_RAMAdresse, z_RAMSchreibDaten, z_RAMLesDaten;
   logic [2:0]  z_WortIndex;
   logic        z_CacheLesGueltig, z_Fertig, z_Beschaeftigt, z_RAMLesen, z_RAMSchreiben;

   // Cache and SRAM models: data derived from index / address.
   assign CacheSchreibDaten   = 32'hA0 + 32'(WortIndex);
   assign RAMLesDaten         = 32'hD000_0000 ^ RAMAdresse;
   assign z_CacheSchreibDaten = 32'hA0 + 32'(z_WortIndex);
   assign z_RAMLesDaten       = 32'hD000_0000 ^ z_RAMAdresse;

   ram_burst_controller dut (
      .Takt(Takt), .nReset(nReset), .Anfrage(Anfrage), .AnfrageSchreiben(AnfrageSchreiben),
      .AnfrageAdresse(AnfrageAdresse), .CacheSchreibDaten(CacheSchreibDaten),
      .WortIndex(WortIndex), .CacheLesDaten(CacheLesDaten), .CacheLesGueltig(CacheLesGueltig),
      .Fertig(Fertig), .Beschaeftigt(Beschaeftigt), .RAMAdresse(RAMAdresse),
      .RAMLesen(RAMLesen), .RAMSchreiben(RAMSchreiben), .RAMSchreibDaten(RAMSchreibDaten),
      .RAMLesDaten(RAMLesDaten));

   ram_burst_controller #(.BLOCKSIZEBITS(5), .WAITSTATES(0)) dut0 (
      .Takt(Takt), .nReset(nReset), .Anfrage(z_Anfrage), .AnfrageSchreiben(z_AnfrageSchreiben),
      .AnfrageAdresse(z_AnfrageAdresse), .CacheSchreibDaten(z_CacheSchreibDaten),
      .WortIndex(z_WortIndex), .CacheLesDaten(z_CacheLesDaten), .CacheLesGueltig(z_CacheLesGueltig),
      .Fertig(z_Fertig), .Beschaeftigt(z_Beschaeftigt), .RAMAdresse(z_RAMAdresse),
      .RAMLesen(z_RAMLesen), .RAMSchreiben(z_RAMSchreiben), .RAMSchreibDaten(z_RAMSchreibDaten),
      .RAMLesDaten(z_RAMLesDaten));

   int cyc = 0;
   always @(posedge Takt) cyc <= cyc + 1;

   int nchk = 0, nerr = 0, z_busy = 0;
   logic [95:0] q_acc[$], q_rd[$], q_fin[$], z_rd[$], z_fin[$];

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string nm, input logic [95:0] act);
      nchk++;
      nerr++;
      $display("FAIL %s: unexpected event %h (cycle %0d)", nm, act, cyc);
   endtask

   // Monitors: every strobe cycle, refill pulse and Fertig pops one entry.
   always @(negedge Takt) begin
      logic [95:0] act;
      if (RAMLesen || RAMSchreiben) begin
         act = {30'b0, RAMSchreiben, RAMLesen, RAMAdresse, RAMSchreiben ? RAMSchreibDaten : 32'h0};
         if (q_acc.size() == 0) unexpected("acc_extra", act);
         else chk("acc", act, q_acc.pop_front());
      end
      if (CacheLesGueltig) begin
         act = {61'b0, WortIndex, CacheLesDaten};
         if (q_rd.size() == 0) unexpected("rd_extra", act);
         else chk("rd", act, q_rd.pop_front());
      end
      if (Fertig) begin
         if (q_fin.size() == 0) unexpected("fin_extra", 96'(cyc));
         else chk("fin_cycle", 96'(cyc), q_fin.pop_front());
      end
      if (z_Beschaeftigt) z_busy++;
      if (z_CacheLesGueltig) begin
         act = {32'(cyc), 29'b0, z_WortIndex, z_CacheLesDaten};
         if (z_rd.size() == 0) unexpected("z_rd_extra", act);
         else chk("z_rd", act, z_rd.pop_front());
      end
      if (z_Fertig) begin
         if (z_fin.size() == 0) unexpected("z_fin_extra", 96'(cyc));
         else chk("z_fin_cycle", 96'(cyc), z_fin.pop_front());
      end
   end

   // Expected burst for the default instance accepted in cycle a.
   task automatic push_burst(input bit wr, input logic [31:0] addr, input int a, input int nwords,
                             input bit fin);
      logic [31:0] base, wa;
      int st, idx;
      base = addr & ~32'h1F;
      st = 0;
`ifdef CRITICAL_WORD_FIRST_EN
      if (!wr) st = int'(addr[4:2]);
`endif
      for (int k = 0; k < nwords; k++) begin
         idx = (st + k) % 8;
         wa = base + 32'(idx * 4);
         for (int c = 0; c < 3; c++)
            q_acc.push_back({30'b0, wr, !wr, wa, wr ? 32'hA0 + 32'(idx) : 32'h0});
         if (!wr) q_rd.push_back({61'b0, 3'(idx), 32'hD000_0000 ^ wa});
      end
      if (fin) q_fin.push_back(96'(a + 25));
   endtask

   task automatic at_cycle(input int n);
      while (cyc < n) begin
         @(posedge Takt);
         #1;
      end
   endtask

   task automatic start(input bit wr, input logic [31:0] addr, output int a);
      @(posedge Takt);
      #1;
      a = cyc;
      Anfrage = 1'b1;
      AnfrageSchreiben = wr;
      AnfrageAdresse = addr;
   endtask

   task automatic chk_idle_zero(input string nm);
      chk({nm, "_ctl"}, {91'b0, Beschaeftigt, Fertig, RAMLesen, RAMSchreiben, CacheLesGueltig}, 96'h0);
      chk({nm, "_idx_addr"}, {61'b0, WortIndex, RAMAdresse}, 96'h0);
      chk({nm, "_data"}, {32'b0, CacheLesDaten, RAMSchreibDaten}, 96'h0);
   endtask

   initial begin
      int a, b;
      nReset = 1'b0;
      Anfrage = 1'b0; AnfrageSchreiben = 1'b0; AnfrageAdresse = '0;
      z_Anfrage = 1'b0; z_AnfrageSchreiben = 1'b0; z_AnfrageAdresse = '0;
      repeat (2) @(posedge Takt);
      #1;
      chk_idle_zero("reset");
      nReset = 1'b1;

      // Refill, defaults.
      start(1'b0, 32'h0000_1234, a);
      push_burst(1'b0, 32'h0000_1234, a, 8, 1'b1);
      at_cycle(a + 1);
`ifdef CRITICAL_WORD_FIRST_EN
      chk("t1_first_addr", 96'(RAMAdresse), 96'h1234);
      at_cycle(a + 24);
      chk("t1_last_addr", 96'(RAMAdresse), 96'h1230);
`else
      chk("t1_first_addr", 96'(RAMAdresse), 96'h1220);
      at_cycle(a + 24);
      chk("t1_last_addr", 96'(RAMAdresse), 96'h123C);
`endif
      at_cycle(a + 25);
      Anfrage = 1'b0;
      chk("t1_fertig_busy", {94'b0, Fertig, Beschaeftigt}, 96'h3);
      at_cycle(a + 27);

      // Writeback, offset inside block must be dropped.
      start(1'b1, 32'h0000_4010, a);
      push_burst(1'b1, 32'h0000_4010, a, 8, 1'b1);
      at_cycle(a + 1);
      chk("t2_first", {32'b0, RAMAdresse, RAMSchreibDaten}, {32'b0, 32'h4000, 32'hA0});
      at_cycle(a + 25);
      Anfrage = 1'b0;
      at_cycle(a + 27);

      // Critical word first candidate: requested word 6.
      start(1'b0, 32'h0000_1238, a);
      push_burst(1'b0, 32'h0000_1238, a, 8, 1'b1);
      at_cycle(a + 1);
`ifdef CRITICAL_WORD_FIRST_EN
      chk("t3_first_addr", 96'(RAMAdresse), 96'h1238);
      at_cycle(a + 7);
      chk("t3_wrap_addr", 96'(RAMAdresse), 96'h1220);
`else
      chk("t3_first_addr", 96'(RAMAdresse), 96'h1220);
      at_cycle(a + 7);
      chk("t3_third_addr", 96'(RAMAdresse), 96'h1228);
`endif
      at_cycle(a + 25);
      Anfrage = 1'b0;
      at_cycle(a + 27);

      // WAITSTATES=0 refill on the second instance.
      @(posedge Takt);
      #1;
      b = cyc;
      z_Anfrage = 1'b1;
      z_AnfrageAdresse = 32'h0000_3000;
      for (int k = 0; k < 8; k++)
         z_rd.push_back({32'(b + 2 + k), 29'b0, 3'(k), 32'hD000_0000 ^ (32'h3000 + 32'(4 * k))});
      z_fin.push_back(96'(b + 9));
      at_cycle(b + 9);
      z_Anfrage = 1'b0;
      at_cycle(b + 12);
      chk("z_busy_cycles", 96'(z_busy), 96'd9);

      // Reset during word 3 of a refill.
      start(1'b0, 32'h0000_8000, a);
      push_burst(1'b0, 32'h0000_8000, a, 3, 1'b0);
      q_acc.push_back({30'b0, 1'b0, 1'b1, 32'h8000 + 32'hC, 32'h0});
      at_cycle(a + 10);
      nReset = 1'b0;
      at_cycle(a + 11);
      nReset = 1'b1;
      Anfrage = 1'b0;
      chk_idle_zero("midrst");
      at_cycle(a + 14);
      chk("midrst_stays_idle", {95'b0, Beschaeftigt}, 96'h0);

      // Request after the aborted burst completes normally.
      start(1'b0, 32'h0000_8000, a);
      push_burst(1'b0, 32'h0000_8000, a, 8, 1'b1);
      at_cycle(a + 25);
      Anfrage = 1'b0;
      at_cycle(a + 27);

      // Anfrage held through Fertig: second burst accepted right after FERTIG.
      start(1'b0, 32'h0000_2000, a);
      push_burst(1'b0, 32'h0000_2000, a, 8, 1'b1);
      push_burst(1'b0, 32'h0000_2000, a + 26, 8, 1'b1);
      at_cycle(a + 26);
      chk("t6_idle_gap", {94'b0, Beschaeftigt, Fertig}, 96'h0);
      at_cycle(a + 51);
      Anfrage = 1'b0;
      chk("t6_second_fertig", {95'b0, Fertig}, 96'h1);
      at_cycle(a + 56);
      chk("t6_idle_after", {95'b0, Beschaeftigt}, 96'h0);

      chk("q_acc_left", 96'(q_acc.size()), 96'h0);
      chk("q_rd_left", 96'(q_rd.size()), 96'h0);
      chk("q_fin_left", 96'(q_fin.size()), 96'h0);
      chk("z_rd_left", 96'(z_rd.size()), 96'h0);
      chk("z_fin_left", 96'(z_fin.size()), 96'h0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
